// File: rtl/smpc_periph_scan_if.sv
// rtl/smpc_periph_scan_if.sv - host/pad bundle for the SMPC peripheral scan engine
interface smpc_periph_scan_if #(
    parameter int PORTS = 2,
    parameter int DEPTH = 32
);
    logic                       CE;
    logic                       START;
    logic                       CONT;
    logic                       BRK;
    logic [PORTS-1:0]           PRESENT;
    logic [16*PORTS-1:0]        JOY;
    logic [$clog2(DEPTH)-1:0]   RADDR;
    logic [7:0]                 RDATA;
    logic                       BUSY;
    logic                       DONE;
    logic                       PDE;

    modport master (
        output CE, START, CONT, BRK, PRESENT, JOY, RADDR,
        input  RDATA, BUSY, DONE, PDE
    );

    modport slave (
        input  CE, START, CONT, BRK, PRESENT, JOY, RADDR,
        output RDATA, BUSY, DONE, PDE
    );
endinterface

// File: rtl/smpc_periph_scan.sv
// rtl/smpc_periph_scan.sv - SMPC INTBACK pad scan engine with batched OREG buffer
// Optional WAIT auto-break is enabled by defining SMPC_SCAN_TIMEOUT_EN.
module smpc_periph_scan #(
    parameter int PORTS   = 2,
    parameter int DEPTH   = 32,
    parameter int TIMEOUT = 1000000
) (
    input  logic              CLK,
    input  logic              RST,
    smpc_periph_scan_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(PORTS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_EMIT,
        S_PAD,
        S_FIN,
        S_WAIT
    } state_t;

    state_t              state, state_n;
    logic [AW-1:0]       wptr, wptr_n;
    logic [PW-1:0]       port_idx, port_n;
    logic [1:0]          rec_idx, rec_n;
    logic [PORTS-1:0]    snap_pres;
    logic [16*PORTS-1:0] snap_joy;
    logic [7:0]          mem [DEPTH];
    logic                wr_en;
    logic [7:0]          wr_data;
    logic [15:0]         cur_joy;
    logic                cur_pres;
    logic                nxt_pres;
    logic                rec_last;
    logic                wptr_last;
    logic                last_port;
    logic                more_ports;
    logic [AW:0]         room;
    logic [AW:0]         next_len;
    logic                tmo_hit;

    always_comb begin
        cur_joy  = 16'h0000;
        cur_pres = 1'b0;
        nxt_pres = 1'b0;
        for (int p = 0; p < PORTS; p++) begin
            if (port_idx == PW'(p)) begin
                cur_joy  = snap_joy[16*p +: 16];
                cur_pres = snap_pres[p];
            end
        end
        for (int p = 1; p < PORTS; p++) begin
            if (port_idx == PW'(p - 1)) nxt_pres = snap_pres[p];
        end
    end

    assign rec_last   = !cur_pres || (rec_idx == 2'd3);
    assign wptr_last  = (wptr == AW'(DEPTH - 1));
    assign last_port  = (port_idx == PW'(PORTS - 1));
    assign more_ports = (port_idx != PW'(PORTS));
    // Bytes still free after the one being written now; used to decide fit one cycle early.
    assign room       = (AW+1)'(DEPTH - 1) - {1'b0, wptr};
    assign next_len   = nxt_pres ? (AW+1)'(4) : (AW+1)'(1);

`ifdef SMPC_SCAN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            tmo_cnt <= '0;
        end else if (bus.CE) begin
            if (state == S_WAIT) tmo_cnt <= tmo_cnt + 1'b1;
            else                 tmo_cnt <= '0;
        end
    end

    assign tmo_hit = (state == S_WAIT) && (tmo_cnt == TW'(TIMEOUT - 1));
`else
    logic tmo_unused;
    assign tmo_unused = (TIMEOUT != 0);
    assign tmo_hit    = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST)         state <= S_IDLE;
        else if (bus.CE) state <= state_n;
    end

    always_comb begin
        state_n = state;
        wptr_n  = wptr;
        port_n  = port_idx;
        rec_n   = rec_idx;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        case (state)
            S_IDLE: begin
                if (bus.START) state_n = S_LATCH;
            end
            S_LATCH: begin
                state_n = S_EMIT;
                wptr_n  = '0;
                port_n  = '0;
                rec_n   = '0;
            end
            S_EMIT: begin
                wr_en  = 1'b1;
                wptr_n = wptr + 1'b1;
                case (rec_idx)
                    2'd0:    wr_data = cur_pres ? 8'hF1 : 8'hF0;
                    2'd1:    wr_data = 8'h02;
                    2'd2:    wr_data = cur_joy[15:8];
                    default: wr_data = cur_joy[7:0];
                endcase
                if (rec_last) begin
                    rec_n  = 2'd0;
                    port_n = port_idx + 1'b1;
                    if (wptr_last)                           state_n = S_FIN;
                    else if (last_port || (room < next_len)) state_n = S_PAD;
                end else begin
                    rec_n = rec_idx + 1'b1;
                end
            end
            S_PAD: begin
                wr_en  = 1'b1;
                wptr_n = wptr + 1'b1;
                if (wptr_last) state_n = S_FIN;
            end
            S_FIN: begin
                state_n = more_ports ? S_WAIT : S_IDLE;
            end
            S_WAIT: begin
                if (bus.BRK) begin
                    state_n = S_IDLE;
                end else if (bus.CONT) begin
                    state_n = S_EMIT;
                    wptr_n  = '0;
                    rec_n   = '0;
                end else if (tmo_hit) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wptr      <= '0;
            port_idx  <= '0;
            rec_idx   <= '0;
            snap_pres <= '0;
            snap_joy  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
        end else if (bus.CE) begin
            wptr     <= wptr_n;
            port_idx <= port_n;
            rec_idx  <= rec_n;
            if (state == S_LATCH) begin
                snap_pres <= bus.PRESENT;
                snap_joy  <= bus.JOY;
            end
            if (wr_en) mem[wptr] <= wr_data;
        end
    end

    // Read port ignores CE so the host can poll the buffer at any time.
    always_ff @(posedge CLK) begin
        if (RST)                                          bus.RDATA <= 8'h00;
        else if ({1'b0, bus.RADDR} < (AW+1)'(DEPTH))      bus.RDATA <= mem[bus.RADDR];
        else                                              bus.RDATA <= 8'h00;
    end

    assign bus.BUSY = (state != S_IDLE);
    assign bus.DONE = (state == S_FIN);
    assign bus.PDE  = ((state == S_FIN) && more_ports) || (state == S_WAIT);
endmodule

// File: tb/tb_smpc_periph_scan.sv
// tb/tb_smpc_periph_scan.sv - directed self-checking bench for smpc_periph_scan
module tb_smpc_periph_scan;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_buf [32];

    always #5 CLK = ~CLK;

    smpc_periph_scan_if #(.PORTS(2),  .DEPTH(32)) b2  ();
    smpc_periph_scan_if #(.PORTS(12), .DEPTH(32)) b12 ();
    smpc_periph_scan_if #(.PORTS(12), .DEPTH(30)) b30 ();

    smpc_periph_scan #(.PORTS(2),  .DEPTH(32), .TIMEOUT(16))  u2  (.CLK(CLK), .RST(RST), .bus(b2));
    smpc_periph_scan #(.PORTS(12), .DEPTH(32), .TIMEOUT(200)) u12 (.CLK(CLK), .RST(RST), .bus(b12));
    smpc_periph_scan #(.PORTS(12), .DEPTH(30), .TIMEOUT(16))  u30 (.CLK(CLK), .RST(RST), .bus(b30));

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic done_of(input int w);
        case (w)
            0:       return b2.DONE;
            1:       return b12.DONE;
            default: return b30.DONE;
        endcase
    endfunction

    task automatic rd(input int w, input int a, output logic [7:0] d);
        case (w)
            0:       b2.RADDR  = 5'(a);
            1:       b12.RADDR = 5'(a);
            default: b30.RADDR = 5'(a);
        endcase
        tick();
        case (w)
            0:       d = b2.RDATA;
            1:       d = b12.RDATA;
            default: d = b30.RDATA;
        endcase
    endtask

    task automatic wait_done(input int w, input int first, input int limit, output int k);
        k = -1;
        for (int i = first; i <= limit && k < 0; i++) begin
            tick();
            if (done_of(w)) k = i;
        end
    endtask

    task automatic set_mtap_joy(input int w);
        for (int p = 0; p < 12; p++) begin
            if (w == 1) b12.JOY[16*p +: 16] = {8'(8'hA0 + p), 8'(8'h50 + p)};
            else        b30.JOY[16*p +: 16] = {8'(8'hA0 + p), 8'(8'h50 + p)};
        end
    endtask

    task automatic test_reset();
        logic [7:0] d;
        RST = 1'b1;
        repeat (3) tick();
        RST = 1'b0;
        checks++; if (b2.BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", b2.BUSY); end
        checks++; if (b2.DONE !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", b2.DONE); end
        checks++; if (b2.PDE !== 1'b0) begin errors++; $display("FAIL reset_pde: got %b expected 0", b2.PDE); end
        checks++; if (b2.RDATA !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %02h expected 00", b2.RDATA); end
        checks++; if (b12.BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy12: got %b expected 0", b12.BUSY); end
        rd(1, 17, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_buf: got %02h expected 00", d); end
    endtask

    task automatic test_two_port();
        int k;
        logic [7:0] d;
        b2.PRESENT = 2'b11;
        b2.JOY     = {16'hFF7E, 16'hFFFF};
        b2.START = 1'b1; tick(); b2.START = 1'b0;
        wait_done(0, 2, 80, k);
        checks++; if (k != 34) begin errors++; $display("FAIL two_port done_cycle: got %0d expected 34", k); end
        checks++; if (b2.PDE !== 1'b0) begin errors++; $display("FAIL two_port pde: got %b expected 0", b2.PDE); end
        tick();
        checks++; if (b2.BUSY !== 1'b0) begin errors++; $display("FAIL two_port busy_after: got %b expected 0", b2.BUSY); end
        for (int i = 0; i < 32; i++) exp_buf[i] = 8'h00;
        exp_buf[0] = 8'hF1; exp_buf[1] = 8'h02; exp_buf[2] = 8'hFF; exp_buf[3] = 8'hFF;
        exp_buf[4] = 8'hF1; exp_buf[5] = 8'h02; exp_buf[6] = 8'hFF; exp_buf[7] = 8'h7E;
        for (int i = 0; i < 32; i++) begin
            rd(0, i, d);
            checks++;
            if (d !== exp_buf[i]) begin errors++; $display("FAIL two_port byte%0d: got %02h expected %02h", i, d, exp_buf[i]); end
        end
    endtask

    task automatic test_absent();
        int k;
        logic [7:0] d;
        b2.PRESENT = 2'b10;
        b2.JOY     = {16'hA55A, 16'h1234};
        b2.START = 1'b1; tick(); b2.START = 1'b0;
        wait_done(0, 2, 80, k);
        checks++; if (k != 34) begin errors++; $display("FAIL absent done_cycle: got %0d expected 34", k); end
        for (int i = 0; i < 32; i++) exp_buf[i] = 8'h00;
        exp_buf[0] = 8'hF0; exp_buf[1] = 8'hF1; exp_buf[2] = 8'h02; exp_buf[3] = 8'hA5; exp_buf[4] = 8'h5A;
        for (int i = 0; i < 32; i++) begin
            rd(0, i, d);
            checks++;
            if (d !== exp_buf[i]) begin errors++; $display("FAIL absent byte%0d: got %02h expected %02h", i, d, exp_buf[i]); end
        end
    endtask

    task automatic test_start_ignored();
        int k;
        b2.PRESENT = 2'b11;
        b2.START = 1'b1; tick(); b2.START = 1'b0;
        repeat (4) tick();
        b2.START = 1'b1; tick(); b2.START = 1'b0;
        wait_done(0, 7, 80, k);
        checks++; if (k != 34) begin errors++; $display("FAIL start_ignored done_cycle: got %0d expected 34", k); end
        repeat (4) tick();
        checks++; if (b2.BUSY !== 1'b0) begin errors++; $display("FAIL start_ignored busy: got %b expected 0", b2.BUSY); end
    endtask

    task automatic test_ce_hold();
        int k;
        logic seen;
        seen = 1'b0;
        b2.START = 1'b1; tick(); b2.START = 1'b0;
        repeat (2) tick();
        b2.CE = 1'b0;
        repeat (5) begin tick(); if (b2.DONE) seen = 1'b1; end
        checks++; if (b2.BUSY !== 1'b1 || seen !== 1'b0) begin errors++; $display("FAIL ce_hold frozen: busy %b done_seen %b expected 1 0", b2.BUSY, seen); end
        b2.CE = 1'b1;
        wait_done(0, 9, 80, k);
        checks++; if (k != 39) begin errors++; $display("FAIL ce_hold done_cycle: got %0d expected 39", k); end
        tick();
    endtask

    task automatic test_rst_mid();
        logic [7:0] d;
        b2.START = 1'b1; tick(); b2.START = 1'b0;
        repeat (8) tick();
        RST = 1'b1; tick(); RST = 1'b0;
        checks++; if (b2.BUSY !== 1'b0) begin errors++; $display("FAIL rst_mid busy: got %b expected 0", b2.BUSY); end
        checks++; if (b2.PDE !== 1'b0) begin errors++; $display("FAIL rst_mid pde: got %b expected 0", b2.PDE); end
        for (int i = 0; i < 32; i++) begin
            rd(0, i, d);
            checks++;
            if (d !== 8'h00) begin errors++; $display("FAIL rst_mid byte%0d: got %02h expected 00", i, d); end
        end
    endtask

    task automatic test_multitap();
        int k;
        logic [7:0] d;
        b12.PRESENT = 12'hFFF;
        set_mtap_joy(1);
        b12.START = 1'b1; tick(); b12.START = 1'b0;
        wait_done(1, 2, 80, k);
        checks++; if (k != 34) begin errors++; $display("FAIL multitap done_cycle: got %0d expected 34", k); end
        checks++; if (b12.PDE !== 1'b1) begin errors++; $display("FAIL multitap pde1: got %b expected 1", b12.PDE); end
        tick();
        checks++; if (b12.BUSY !== 1'b1 || b12.PDE !== 1'b1) begin errors++; $display("FAIL multitap wait: busy %b pde %b expected 1 1", b12.BUSY, b12.PDE); end
        b12.JOY = '0;
        for (int p = 0; p < 8; p++) begin
            exp_buf[4*p] = 8'hF1; exp_buf[4*p+1] = 8'h02;
            exp_buf[4*p+2] = 8'(8'hA0 + p); exp_buf[4*p+3] = 8'(8'h50 + p);
        end
        for (int i = 0; i < 32; i++) begin
            rd(1, i, d);
            checks++;
            if (d !== exp_buf[i]) begin errors++; $display("FAIL multitap b1_byte%0d: got %02h expected %02h", i, d, exp_buf[i]); end
        end
        b12.CONT = 1'b1; tick(); b12.CONT = 1'b0;
        wait_done(1, 2, 80, k);
        checks++; if (k != 33) begin errors++; $display("FAIL multitap cont_done_cycle: got %0d expected 33", k); end
        checks++; if (b12.PDE !== 1'b0) begin errors++; $display("FAIL multitap pde2: got %b expected 0", b12.PDE); end
        tick();
        checks++; if (b12.BUSY !== 1'b0) begin errors++; $display("FAIL multitap busy_after: got %b expected 0", b12.BUSY); end
        for (int i = 0; i < 32; i++) exp_buf[i] = 8'h00;
        for (int p = 8; p < 12; p++) begin
            exp_buf[4*(p-8)] = 8'hF1; exp_buf[4*(p-8)+1] = 8'h02;
            exp_buf[4*(p-8)+2] = 8'(8'hA0 + p); exp_buf[4*(p-8)+3] = 8'(8'h50 + p);
        end
        for (int i = 0; i < 32; i++) begin
            rd(1, i, d);
            checks++;
            if (d !== exp_buf[i]) begin errors++; $display("FAIL multitap b2_byte%0d: got %02h expected %02h", i, d, exp_buf[i]); end
        end
    endtask

    task automatic test_break();
        int k;
        logic seen;
        set_mtap_joy(1);
        b12.START = 1'b1; tick(); b12.START = 1'b0;
        wait_done(1, 2, 80, k);
        checks++; if (k != 34 || b12.PDE !== 1'b1) begin errors++; $display("FAIL break setup: done_cycle %0d pde %b expected 34 1", k, b12.PDE); end
        tick();
        b12.CONT = 1'b1; b12.BRK = 1'b1; tick(); b12.CONT = 1'b0; b12.BRK = 1'b0;
        checks++; if (b12.BUSY !== 1'b0) begin errors++; $display("FAIL break busy: got %b expected 0", b12.BUSY); end
        checks++; if (b12.PDE !== 1'b0) begin errors++; $display("FAIL break pde: got %b expected 0", b12.PDE); end
        b12.CONT = 1'b1; tick(); b12.CONT = 1'b0;
        seen = 1'b0;
        repeat (40) begin tick(); if (b12.DONE || b12.BUSY) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL break idle_cont: activity %b expected 0", seen); end
    endtask

    task automatic test_no_split();
        int k;
        b30.PRESENT = 12'hFFF;
        set_mtap_joy(2);
        b30.START = 1'b1; tick(); b30.START = 1'b0;
        wait_done(2, 2, 80, k);
        checks++; if (k != 32) begin errors++; $display("FAIL no_split done_cycle: got %0d expected 32", k); end
        checks++; if (b30.PDE !== 1'b1) begin errors++; $display("FAIL no_split pde: got %b expected 1", b30.PDE); end
    endtask

    task automatic test_timeout();
        logic seen;
        logic [7:0] d;
        seen = 1'b0;
        repeat (16) begin tick(); if (b30.DONE) seen = 1'b1; end
        checks++; if (b30.BUSY !== 1'b1) begin errors++; $display("FAIL timeout early: busy %b expected 1", b30.BUSY); end
`ifdef SMPC_SCAN_TIMEOUT_EN
        tick(); if (b30.DONE) seen = 1'b1;
        checks++; if (b30.BUSY !== 1'b0 || b30.PDE !== 1'b0) begin errors++; $display("FAIL timeout expire: busy %b pde %b expected 0 0", b30.BUSY, b30.PDE); end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL timeout done_pulse: got %b expected 0", seen); end
`else
        repeat (984) begin tick(); if (b30.DONE) seen = 1'b1; end
        checks++; if (b30.BUSY !== 1'b1 || b30.PDE !== 1'b1) begin errors++; $display("FAIL no_timeout hold: busy %b pde %b expected 1 1", b30.BUSY, b30.PDE); end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL no_timeout done_pulse: got %b expected 0", seen); end
        b30.BRK = 1'b1; tick(); b30.BRK = 1'b0;
        checks++; if (b30.BUSY !== 1'b0) begin errors++; $display("FAIL no_timeout brk: busy %b expected 0", b30.BUSY); end
`endif
        for (int i = 0; i < 32; i++) exp_buf[i] = 8'h00;
        for (int p = 0; p < 7; p++) begin
            exp_buf[4*p] = 8'hF1; exp_buf[4*p+1] = 8'h02;
            exp_buf[4*p+2] = 8'(8'hA0 + p); exp_buf[4*p+3] = 8'(8'h50 + p);
        end
        for (int i = 0; i < 30; i++) begin
            rd(2, i, d);
            checks++;
            if (d !== exp_buf[i]) begin errors++; $display("FAIL no_split byte%0d: got %02h expected %02h", i, d, exp_buf[i]); end
        end
    endtask

    initial begin
        b2.CE  = 1'b1; b2.START  = 1'b0; b2.CONT  = 1'b0; b2.BRK  = 1'b0; b2.PRESENT  = '0; b2.JOY  = '0; b2.RADDR  = '0;
        b12.CE = 1'b1; b12.START = 1'b0; b12.CONT = 1'b0; b12.BRK = 1'b0; b12.PRESENT = '0; b12.JOY = '0; b12.RADDR = '0;
        b30.CE = 1'b1; b30.START = 1'b0; b30.CONT = 1'b0; b30.BRK = 1'b0; b30.PRESENT = '0; b30.JOY = '0; b30.RADDR = '0;
        test_reset();
        test_two_port();
        test_absent();
        test_start_ignored();
        test_ce_hold();
        test_rst_mid();
        test_multitap();
        test_break();
        test_no_split();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
